// File: rtl/mips_multicycle_control_pkg.sv
// Shared types and constants for the multi-cycle MIPS control FSM:
// state encoding, mux select codes, ALU op codes and default opcodes.
package mips_mc_pkg;

  typedef enum logic [3:0] {
    S_RESET  = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_RTWB   = 4'd8,
    S_BRANCH = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11,
    S_JUMP   = 4'd12,
    S_TRAP   = 4'd13
  } state_e;

  localparam int ALUOP_ADD   = 0;
  localparam int ALUOP_SUB   = 1;
  localparam int ALUOP_FUNCT = 2;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

  localparam logic [1:0] SRCB_B       = 2'd0;
  localparam logic [1:0] SRCB_FOUR    = 2'd1;
  localparam logic [1:0] SRCB_IMM     = 2'd2;
  localparam logic [1:0] SRCB_IMM_SL2 = 2'd3;

  localparam logic [5:0] OP_RTYPE_DEF = 6'd0;
  localparam logic [5:0] OP_LW_DEF    = 6'd35;
  localparam logic [5:0] OP_SW_DEF    = 6'd43;
  localparam logic [5:0] OP_BEQ_DEF   = 6'd4;
  localparam logic [5:0] OP_ADDI_DEF  = 6'd8;
  localparam logic [5:0] OP_J_DEF     = 6'd2;

endpackage

// File: rtl/mips_multicycle_control_if.sv
// Control-to-datapath bundle: opcode and memory handshake in, datapath
// control lines out. The control block takes master, the datapath slave.
interface mips_multicycle_control_if #(
  parameter int ALUOP_W = 3
);
  logic [5:0]         Op;
  logic               mem_ready;
  logic               PCWrite;
  logic               PCWriteCond;
  logic               IorD;
  logic               MemRead;
  logic               MemWrite;
  logic               IRWrite;
  logic               MemtoReg;
  logic               ALUSrcA;
  logic               RegWrite;
  logic               RegDst;
  logic [1:0]         PCSource;
  logic [1:0]         ALUSrcB;
  logic [ALUOP_W-1:0] ALUOp;
  logic               illegal;
  logic               instr_done;

  modport master (
    input  Op, mem_ready,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
           ALUSrcA, RegWrite, RegDst, PCSource, ALUSrcB, ALUOp, illegal,
           instr_done
  );

  modport slave (
    output Op, mem_ready,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
           ALUSrcA, RegWrite, RegDst, PCSource, ALUSrcB, ALUOp, illegal,
           instr_done
  );
endinterface

// File: rtl/mips_multicycle_control_next_state.sv
// Combinational next-state logic for the multi-cycle control FSM. The live
// opcode is decoded only in DECODE; MEMADR steers on the latched copy.
module mc_next_state
  import mips_mc_pkg::*;
#(
  parameter logic [5:0] OP_RTYPE = OP_RTYPE_DEF,
  parameter logic [5:0] OP_LW    = OP_LW_DEF,
  parameter logic [5:0] OP_SW    = OP_SW_DEF,
  parameter logic [5:0] OP_BEQ   = OP_BEQ_DEF,
  parameter logic [5:0] OP_ADDI  = OP_ADDI_DEF,
  parameter logic [5:0] OP_J     = OP_J_DEF
) (
  input  state_e     state_q,
  input  logic [5:0] op,
  input  logic [5:0] op_q,
  input  logic       mem_ready,
  output state_e     state_d
);

  always_comb begin
    // NOTE: default assignment first so every path drives state_d and no latch is inferred.
    state_d = state_q;
    case (state_q)
      S_RESET:  state_d = S_FETCH;
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        if (op == OP_LW || op == OP_SW) state_d = S_MEMADR;
        else if (op == OP_RTYPE)        state_d = S_EXEC;
        else if (op == OP_BEQ)          state_d = S_BRANCH;
        else if (op == OP_ADDI)         state_d = S_ADDIEX;
        else if (op == OP_J)            state_d = S_JUMP;
        else                            state_d = S_TRAP;
      end
      S_MEMADR: state_d = (op_q == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  if (mem_ready) state_d = S_FETCH;
      S_EXEC:   state_d = S_RTWB;
      S_RTWB:   state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_ADDIEX: state_d = S_ADDIWB;
      S_ADDIWB: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      S_TRAP:   state_d = S_TRAP;
      // Unused encodings fall back to a clean restart.
      default:  state_d = S_RESET;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_control.sv
// Moore control FSM for the multi-cycle MIPS datapath. Holds the state and
// latched opcode; outputs decode from the state, gated by mem_ready in FETCH/MEMWR.
module mips_multicycle_control
  import mips_mc_pkg::*;
#(
  parameter int         ALUOP_W  = 3,
  parameter logic [5:0] OP_RTYPE = OP_RTYPE_DEF,
  parameter logic [5:0] OP_LW    = OP_LW_DEF,
  parameter logic [5:0] OP_SW    = OP_SW_DEF,
  parameter logic [5:0] OP_BEQ   = OP_BEQ_DEF,
  parameter logic [5:0] OP_ADDI  = OP_ADDI_DEF,
  parameter logic [5:0] OP_J     = OP_J_DEF
) (
  input logic                        clk,
  input logic                        rst,
  mips_multicycle_control_if.master  bus
);

  state_e     state_q, state_d;
  logic [5:0] op_q, op_d;

  mc_next_state #(
    .OP_RTYPE (OP_RTYPE),
    .OP_LW    (OP_LW),
    .OP_SW    (OP_SW),
    .OP_BEQ   (OP_BEQ),
    .OP_ADDI  (OP_ADDI),
    .OP_J     (OP_J)
  ) u_next_state (
    .state_q   (state_q),
    .op        (bus.Op),
    .op_q      (op_q),
    .mem_ready (bus.mem_ready),
    .state_d   (state_d)
  );

  always_comb op_d = (state_q == S_DECODE) ? bus.Op : op_q;

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments for all state so every flop samples pre-edge values.
    if (rst) begin
      state_q <= S_RESET;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  // Async reset drops state_q to RESET, so outputs clear without waiting for a clock.
  always_comb begin
    bus.PCWrite     = 1'b0;
    bus.PCWriteCond = 1'b0;
    bus.IorD        = 1'b0;
    bus.MemRead     = 1'b0;
    bus.MemWrite    = 1'b0;
    bus.IRWrite     = 1'b0;
    bus.MemtoReg    = 1'b0;
    bus.ALUSrcA     = 1'b0;
    bus.RegWrite    = 1'b0;
    bus.RegDst      = 1'b0;
    bus.PCSource    = PCSRC_ALU;
    bus.ALUSrcB     = SRCB_B;
    bus.ALUOp       = ALUOP_W'(ALUOP_ADD);
    bus.illegal     = 1'b0;
    bus.instr_done  = 1'b0;
    case (state_q)
      S_FETCH: begin
        bus.MemRead = 1'b1;
        bus.ALUSrcB = SRCB_FOUR;
        bus.IRWrite = bus.mem_ready;
        bus.PCWrite = bus.mem_ready;
      end
      S_DECODE: bus.ALUSrcB = SRCB_IMM_SL2;
      S_MEMADR, S_ADDIEX: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = SRCB_IMM;
      end
      S_MEMRD: begin
        bus.MemRead = 1'b1;
        bus.IorD    = 1'b1;
      end
      S_MEMWB: begin
        bus.RegWrite   = 1'b1;
        bus.MemtoReg   = 1'b1;
        bus.instr_done = 1'b1;
      end
      S_MEMWR: begin
        bus.MemWrite   = 1'b1;
        bus.IorD       = 1'b1;
        bus.instr_done = bus.mem_ready;
      end
      S_EXEC: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUOp   = ALUOP_W'(ALUOP_FUNCT);
      end
      S_RTWB: begin
        bus.RegWrite   = 1'b1;
        bus.RegDst     = 1'b1;
        bus.instr_done = 1'b1;
      end
      S_BRANCH: begin
        bus.ALUSrcA     = 1'b1;
        bus.ALUOp       = ALUOP_W'(ALUOP_SUB);
        bus.PCWriteCond = 1'b1;
        bus.PCSource    = PCSRC_ALUOUT;
        bus.instr_done  = 1'b1;
      end
      S_ADDIWB: begin
        bus.RegWrite   = 1'b1;
        bus.instr_done = 1'b1;
      end
      S_JUMP: begin
        bus.PCWrite    = 1'b1;
        bus.PCSource   = PCSRC_JUMP;
        bus.instr_done = 1'b1;
      end
      S_TRAP:  bus.illegal = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed bench for mips_multicycle_control: default build plus a build with
// OP_LW=40 and a 4-bit ALUOp, checked cycle by cycle against hand-built vectors.
module tb_mips_multicycle_control;

  typedef struct packed {
    logic       pcw, pcwc, iord, mrd, mwr, irw, m2r, srca, rgw, rdst;
    logic [1:0] pcsrc, srcb;
    logic [2:0] aluop;
    logic       ill, done;
  } ctl_t;

  logic clk;
  logic rst;
  int   n_total = 0;
  int   n_pass  = 0;
  int   n_fail  = 0;

  mips_multicycle_control_if #(.ALUOP_W(3)) bus1 ();
  mips_multicycle_control_if #(.ALUOP_W(4)) bus2 ();

  mips_multicycle_control dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  mips_multicycle_control #(
    .ALUOP_W (4),
    .OP_LW   (6'd40)
  ) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  ctl_t obs1, obs2;
  assign obs1 = {bus1.PCWrite, bus1.PCWriteCond, bus1.IorD, bus1.MemRead, bus1.MemWrite,
                 bus1.IRWrite, bus1.MemtoReg, bus1.ALUSrcA, bus1.RegWrite, bus1.RegDst,
                 bus1.PCSource, bus1.ALUSrcB, bus1.ALUOp, bus1.illegal, bus1.instr_done};
  assign obs2 = {bus2.PCWrite, bus2.PCWriteCond, bus2.IorD, bus2.MemRead, bus2.MemWrite,
                 bus2.IRWrite, bus2.MemtoReg, bus2.ALUSrcA, bus2.RegWrite, bus2.RegDst,
                 bus2.PCSource, bus2.ALUSrcB, bus2.ALUOp[2:0], bus2.illegal, bus2.instr_done};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle's inputs at the falling edge, then check that cycle's outputs.
  task automatic step(input int which, input logic rdy, input logic [5:0] op,
                      input ctl_t exp, input string tag);
    @(negedge clk);
    if (which == 1) begin
      bus1.mem_ready = rdy;
      bus1.Op        = op;
    end else begin
      bus2.mem_ready = rdy;
      bus2.Op        = op;
    end
    #1;
    check(tag, 32'(which == 1 ? obs1 : obs2), 32'(exp));
  endtask

  ctl_t e_zero, e_fetch_w, e_fetch_r, e_decode, e_memadr, e_memrd, e_memwb;
  ctl_t e_memwr_w, e_memwr_r, e_exec, e_rtwb, e_branch, e_addiwb, e_jump, e_trap;

  initial begin
    e_zero    = '0;
    e_fetch_w = '0; e_fetch_w.mrd = 1'b1; e_fetch_w.srcb = 2'd1;
    e_fetch_r = e_fetch_w; e_fetch_r.irw = 1'b1; e_fetch_r.pcw = 1'b1;
    e_decode  = '0; e_decode.srcb = 2'd3;
    e_memadr  = '0; e_memadr.srca = 1'b1; e_memadr.srcb = 2'd2;
    e_memrd   = '0; e_memrd.mrd = 1'b1; e_memrd.iord = 1'b1;
    e_memwb   = '0; e_memwb.rgw = 1'b1; e_memwb.m2r = 1'b1; e_memwb.done = 1'b1;
    e_memwr_w = '0; e_memwr_w.mwr = 1'b1; e_memwr_w.iord = 1'b1;
    e_memwr_r = e_memwr_w; e_memwr_r.done = 1'b1;
    e_exec    = '0; e_exec.srca = 1'b1; e_exec.aluop = 3'd2;
    e_rtwb    = '0; e_rtwb.rgw = 1'b1; e_rtwb.rdst = 1'b1; e_rtwb.done = 1'b1;
    e_branch  = '0; e_branch.srca = 1'b1; e_branch.aluop = 3'd1; e_branch.pcwc = 1'b1;
    e_branch.pcsrc = 2'd1; e_branch.done = 1'b1;
    e_addiwb  = '0; e_addiwb.rgw = 1'b1; e_addiwb.done = 1'b1;
    e_jump    = '0; e_jump.pcw = 1'b1; e_jump.pcsrc = 2'd2; e_jump.done = 1'b1;
    e_trap    = '0; e_trap.ill = 1'b1;

    rst = 1'b1;
    bus1.mem_ready = 1'b0; bus1.Op = 6'd0;
    bus2.mem_ready = 1'b0; bus2.Op = 6'd0;
    repeat (2) @(negedge clk);
    #1 check("reset_hold", 32'(obs1), 32'(e_zero));
    @(negedge clk) rst = 1'b0;
    #1 check("reset_release", 32'(obs1), 32'(e_zero));

    // R-type, no stall; mem_ready low outside memory states must not matter.
    step(1, 1'b1, 6'd0, e_fetch_r, "rt_fetch");
    step(1, 1'b0, 6'd0, e_decode,  "rt_decode");
    step(1, 1'b0, 6'd0, e_exec,    "rt_exec");
    step(1, 1'b0, 6'd0, e_rtwb,    "rt_wb");

    // LW: 2 fetch stalls, 3 MEMRD stalls; Op changes after DECODE to prove latching.
    step(1, 1'b0, 6'd35, e_fetch_w, "lw_fetch_stall1");
    step(1, 1'b0, 6'd35, e_fetch_w, "lw_fetch_stall2");
    step(1, 1'b1, 6'd35, e_fetch_r, "lw_fetch_ready");
    step(1, 1'b1, 6'd35, e_decode,  "lw_decode");
    step(1, 1'b1, 6'd43, e_memadr,  "lw_memadr");
    step(1, 1'b0, 6'd43, e_memrd,   "lw_memrd_stall1");
    step(1, 1'b0, 6'd43, e_memrd,   "lw_memrd_stall2");
    step(1, 1'b0, 6'd43, e_memrd,   "lw_memrd_stall3");
    step(1, 1'b1, 6'd43, e_memrd,   "lw_memrd_ready");
    step(1, 1'b1, 6'd43, e_memwb,   "lw_memwb_c10");

    // SW, no stall, then a second SW with one MEMWR stall.
    step(1, 1'b1, 6'd43, e_fetch_r, "sw_fetch");
    step(1, 1'b1, 6'd43, e_decode,  "sw_decode");
    step(1, 1'b1, 6'd35, e_memadr,  "sw_memadr");
    step(1, 1'b1, 6'd35, e_memwr_r, "sw_memwr_c4");
    step(1, 1'b1, 6'd43, e_fetch_r, "sw2_fetch");
    step(1, 1'b1, 6'd43, e_decode,  "sw2_decode");
    step(1, 1'b1, 6'd43, e_memadr,  "sw2_memadr");
    step(1, 1'b0, 6'd43, e_memwr_w, "sw2_memwr_stall");
    step(1, 1'b1, 6'd43, e_memwr_r, "sw2_memwr_ready");

    step(1, 1'b1, 6'd4, e_fetch_r, "beq_fetch");
    step(1, 1'b1, 6'd4, e_decode,  "beq_decode");
    step(1, 1'b1, 6'd4, e_branch,  "beq_branch_c3");
    step(1, 1'b1, 6'd2, e_fetch_r, "j_fetch");
    step(1, 1'b1, 6'd2, e_decode,  "j_decode");
    step(1, 1'b1, 6'd2, e_jump,    "j_jump_c3");
    step(1, 1'b1, 6'd8, e_fetch_r, "addi_fetch");
    step(1, 1'b1, 6'd8, e_decode,  "addi_decode");
    step(1, 1'b1, 6'd8, e_memadr,  "addi_ex");
    step(1, 1'b1, 6'd8, e_addiwb,  "addi_wb_c4");

    // Reset asserted mid-LW while stalled in MEMRD.
    step(1, 1'b1, 6'd35, e_fetch_r, "rlw_fetch");
    step(1, 1'b1, 6'd35, e_decode,  "rlw_decode");
    step(1, 1'b1, 6'd35, e_memadr,  "rlw_memadr");
    step(1, 1'b0, 6'd35, e_memrd,   "rlw_memrd_stall");
    @(negedge clk) rst = 1'b1;
    #1 check("rlw_async_zero", 32'(obs1), 32'(e_zero));
    @(negedge clk) rst = 1'b0;
    #1 check("rlw_release_zero", 32'(obs1), 32'(e_zero));
    step(1, 1'b0, 6'd35, e_fetch_w, "rlw_first_fetch");

    // Illegal opcode: absorbing TRAP regardless of inputs, cleared by reset.
    step(1, 1'b1, 6'd63, e_fetch_r, "ill_fetch");
    step(1, 1'b1, 6'd63, e_decode,  "ill_decode");
    for (int i = 0; i < 20; i++)
      step(1, 1'(i % 2), 6'(i % 4), e_trap, $sformatf("ill_trap_%0d", i));
    @(negedge clk) rst = 1'b1;
    #1 check("ill_rst_zero", 32'(obs1), 32'(e_zero));
    @(negedge clk) rst = 1'b0;
    #1 check("ill_release_zero", 32'(obs1), 32'(e_zero));
    step(1, 1'b0, 6'd0, e_fetch_w, "ill_refetch");

    // Reparametrised build: OP_LW=40, 4-bit ALUOp. DUT2 was reset with the rest.
    step(2, 1'b1, 6'd0,  e_fetch_r, "p2_rt_fetch");
    step(2, 1'b1, 6'd0,  e_decode,  "p2_rt_decode");
    step(2, 1'b1, 6'd0,  e_exec,    "p2_rt_exec");
    check("p2_aluop_width", 32'(bus2.ALUOp), 32'd2);
    step(2, 1'b1, 6'd0,  e_rtwb,    "p2_rt_wb");
    step(2, 1'b1, 6'd40, e_fetch_r, "p2_lw_fetch");
    step(2, 1'b1, 6'd40, e_decode,  "p2_lw_decode");
    step(2, 1'b1, 6'd40, e_memadr,  "p2_lw_memadr");
    step(2, 1'b1, 6'd40, e_memrd,   "p2_lw_memrd");
    step(2, 1'b1, 6'd40, e_memwb,   "p2_lw_memwb");
    step(2, 1'b1, 6'd35, e_fetch_r, "p2_35_fetch");
    step(2, 1'b1, 6'd35, e_decode,  "p2_35_decode");
    step(2, 1'b1, 6'd35, e_trap,    "p2_35_trap");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
